hbus_dline_w: RTL
=================

// Module: hbus_dline_w
//
// PURPOSE
//  Multi-bit, runtime-programmable delay line with per-sample valid tagging.
//  Delays a W-bit data word and its valid flag by 1..2^N cycles.
//  Supports safe on-the-fly delay changes: in-flight samples are flushed, so no sample is ever output twice or at the wrong latency.
//  Sits in the HyperBus PHY datapath to align captured RWDS/DQ words against command timing during latency calibration.
//
// PARAMETERS
//  W          8   data word width (bits)
//  N          3   delay select width; programmable delay range 0..2^N-1
//  DELAY_INIT 0   delay_cur value after reset (0..2^N-1)
//
// PORTS
//  clk        in   1  clock; all logic is on its rising edge
//  rst        in   1  reset, synchronous, active-high
//  di         in   W  input data word
//  di_valid   in   1  input word is valid this cycle
//  do         out  W  delayed data word
//  do_valid   out  1  do carries a valid delayed sample
//  delay_in   in   N  requested delay, sampled when delay_stb=1
//  delay_stb  in   1  single-cycle strobe: load delay_in and flush
//  delay_cur  out  N  delay currently applied
//  busy       out  1  flush in progress; output stream not yet at new latency
//
// BEHAVIOUR
//  Reset (rst=1 at an edge): all pipeline valid bits=0, do_valid=0, do=0, delay_cur=DELAY_INIT, busy=0, flush counter=0.
//   Pipeline data registers need no reset.
//   rst has priority over delay_stb and over any flush in progress.
//  Datapath:
//   - N binary-weighted stages.
//   - Stage i is a (1<<i)-deep shift register of {di_valid,di} (W+1 bits).
//   - Stage i is bypassed when delay_cur[i]=0.
//   - Final output register is always present.
//  Latency: a sample presented in cycle t appears on {do_valid,do} in cycle t+delay_cur+1. delay_cur=0 gives 1 cycle.
//  Bubbles (di_valid=0) propagate unchanged; the valid pattern is preserved exactly.
//  do may hold any value while do_valid=0; only do_valid qualifies data.
//  Delay change, delay_stb=1 in cycle s:
//   - Edge s: delay_cur<=delay_in.
//   - Edge s: every pipeline valid bit, including the output register, is cleared. The di sample of cycle s is also discarded.
//   - Edge s: flush counter <= delay_in+1.
//   - Samples from cycle s+1 onward use the new delay. The first can reach do in cycle s+2+delay_in.
//   - do_valid=0 from cycle s+1 until that first post-change sample arrives.
//  busy = (flush counter != 0).
//   - High in cycles s+1 .. s+1+delay_in.
//   - Falls in the same cycle the first post-change sample can appear.
//   - The counter decrements by 1 per cycle while nonzero.
//  Strobe while busy: same action as above. The counter reloads from the new delay_in and the pipeline is flushed again.
//  Strobe with delay_in==delay_cur: the full flush is still performed, for deterministic timing.
//  Counter width: N+1 bits; max load 2^N, so no overflow.
//  Two-state FSM, implicit in the counter: IDLE (cnt=0) -> FLUSH on delay_stb; FLUSH -> IDLE when cnt reaches 0.
//  No combinational path from any input to any output.
//
// TESTING
//  1. Reset with DELAY_INIT=2, hold di_valid=1 with di counting from 0 -> do_valid first rises 3 cycles after rst falls; do=0,1,2,...
//  2. Latency sweep d=0..7, single valid pulse di=0xA5 -> do_valid pulse exactly d+1 cycles later, do=0xA5; no other do_valid pulses.
//  3. Continuous count stream at d=2, strobe delay_in=5 in cycle s:
//     - busy is high for 6 cycles;
//     - do_valid is 0 from s+1 through s+6;
//     - the first valid do equals the di of cycle s+1, at s+7;
//     - no value repeats.
//  4. Continuous stream at d=5, strobe delay_in=1 -> do_valid low for 2 cycles, then resumes at latency 2. Every pre-strobe value still in flight is dropped; none are duplicated.
//  5. Strobe delay_in=7, then strobe delay_in=3 three cycles later while busy -> busy extends to 4 cycles after the second strobe; latency is 4 afterwards.
//  6. Streaming with bubbles (valid pattern 1101) at d=4, rst asserted mid-stream for 1 cycle -> do_valid=0 and delay_cur=DELAY_INIT the next cycle. Post-reset bubble pattern is preserved exactly.

Source files
------------

// File: rtl/hbus_dline_w.sv
// Programmable delay line for HyperBus PHY capture alignment: delays {valid,data}
// by delay_cur+1 cycles and flushes the pipeline cleanly on every delay change.
module hbus_dline_w #(
  parameter int W          = 8,
  parameter int N          = 3,
  parameter int DELAY_INIT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] di_i,
  input  logic         di_valid_i,
  output logic [W-1:0] do_o,
  output logic         do_valid_o,
  input  logic [N-1:0] delay_in_i,
  input  logic         delay_stb_i,
  output logic [N-1:0] delay_cur_o,
  output logic         busy_o
);

  logic [N-1:0] delay_cur_q, delay_cur_d;
  logic [N:0]   cnt_q, cnt_d;
  logic [W-1:0] do_q, do_d;
  logic         do_valid_q, do_valid_d;
  logic [W:0]   pipe_out;

  // Stage i holds 2^i samples and is switched in when delay_cur[i] is set, so the
  // enabled stages sum to exactly delay_cur extra cycles.
  for (genvar i = 0; i < N; i++) begin : g_stage
    localparam int LEN = 1 << i;

    logic [W:0]     stg_in;
    logic [W:0]     stg_out;
    logic [W-1:0]   sr_data_q [LEN];
    logic [LEN-1:0] sr_vld_q;

    if (i == 0) begin : g_first
      assign stg_in = {di_valid_i, di_i};
    end else begin : g_next
      assign stg_in = g_stage[i-1].stg_out;
    end

    // NOTE: data words carry no reset; only the valid bits decide what is real,
    // which keeps the shift registers free of reset fan-out.
    always_ff @(posedge clk) begin
      sr_data_q[0] <= stg_in[W-1:0];
      for (int k = 1; k < LEN; k++) sr_data_q[k] <= sr_data_q[k-1];
    end

    // A strobe clears every valid bit, bypassed stages included, so stale samples
    // can never resurface when a stage is later switched back in.
    always_ff @(posedge clk) begin
      if (rst || delay_stb_i) begin
        sr_vld_q <= '0;
      end else begin
        sr_vld_q[0] <= stg_in[W];
        for (int k = 1; k < LEN; k++) sr_vld_q[k] <= sr_vld_q[k-1];
      end
    end

    assign stg_out = delay_cur_q[i] ? {sr_vld_q[LEN-1], sr_data_q[LEN-1]} : stg_in;
  end

  assign pipe_out = g_stage[N-1].stg_out;

  // NOTE: every next-state variable gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    delay_cur_d = delay_cur_q;
    cnt_d       = cnt_q;
    do_d        = pipe_out[W-1:0];
    do_valid_d  = pipe_out[W];
    if (delay_stb_i) begin
      delay_cur_d = delay_in_i;
      cnt_d       = {1'b0, delay_in_i} + (N+1)'(1);
      do_valid_d  = 1'b0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - (N+1)'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      delay_cur_q <= N'(DELAY_INIT);
      cnt_q       <= '0;
      do_q        <= '0;
      do_valid_q  <= 1'b0;
    end else begin
      delay_cur_q <= delay_cur_d;
      cnt_q       <= cnt_d;
      do_q        <= do_d;
      do_valid_q  <= do_valid_d;
    end
  end

  assign do_o        = do_q;
  assign do_valid_o  = do_valid_q;
  assign delay_cur_o = delay_cur_q;
  assign busy_o      = (cnt_q != '0);

endmodule
